// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
//   CLA_GROUP_DEFAULT : default number of bits per lookahead group.
//   stage_ctl_t       : control part of a pipeline stage register
//                       (valid, carry out of the resolved slice, Sub).
//                       The width-dependent parts (partial sum, remaining
//                       A/Beff) are sized by the top-level parameters.
//   width_ok()        : elaboration-time check of the width split.
package cla_pkg;

  localparam int unsigned CLA_GROUP_DEFAULT = 4;

  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
  } stage_ctl_t;

  function automatic bit width_ok(input int unsigned width,
                                  input int unsigned group,
                                  input int unsigned stages);
    return (group != 0) && (stages != 0) && (width != 0) &&
           ((width % (group * stages)) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit carry-lookahead slice.
//   a, b : operand bits of this group (b already inverted for subtract)
//   cin  : carry into the group
//   s    : sum bits
//   g, p : group generate / group propagate (independent of cin)
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] bg;
  logic [GROUP-1:0] bp;
  logic [GROUP-1:0] c;

  assign bg = a & b;
  assign bp = a ^ b;
  assign p  = &bp;
  assign s  = bp ^ c;

  // Flat lookahead: each carry is a sum of products, no ripple chain.
  always_comb begin : carries
    logic ci;
    logic t;
    c  = '0;
    ci = 1'b0;
    t  = 1'b0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      ci = cin;
      for (int unsigned m = 0; m < i; m++) ci = ci & bp[m];
      for (int unsigned j = 0; j < i; j++) begin
        t = bg[j];
        for (int unsigned m = j + 1; m < i; m++) t = t & bp[m];
        ci = ci | t;
      end
      c[i] = ci;
    end
  end

  // Kept in its own block so that g never appears to depend on cin.
  always_comb begin : group_gen
    logic t;
    g = 1'b0;
    t = 1'b0;
    for (int unsigned j = 0; j < GROUP; j++) begin
      t = bg[j];
      for (int unsigned m = j + 1; m < GROUP; m++) t = t & bp[m];
      g = g | t;
    end
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: parametrised pipelined carry-lookahead add/subtract
// with valid/ready handshake and full backpressure.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake (A, B, Cin, Sub)
//   out_valid/out_ready : output beat handshake (S, Cout[, Ovf])
//   Sub=0: S = A+B+Cin;  Sub=1: S = A-B-Cin, Cout=1 means no borrow.
// Optional feature: define CLA_OVF_EN to add the registered signed
// overflow output Ovf.
// Stage k resolves bits [k*WIDTH/STAGES +: WIDTH/STAGES] from the carry
// registered by stage k-1; latency is STAGES cycles, 1 beat/cycle.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned GROUP  = CLA_GROUP_DEFAULT,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef CLA_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned SW   = WIDTH / STAGES;  // bits per stage
  localparam int unsigned NG   = WIDTH / GROUP;   // total groups
  localparam int unsigned GPS  = SW / GROUP;      // groups per stage
  localparam int unsigned LAST = STAGES - 1;

  if (!width_ok(WIDTH, GROUP, STAGES)) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP*STAGES");
  end

  // Stage registers
  stage_ctl_t       ctl_q [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];  // resolved low slices
  logic [WIDTH-1:0] a_q   [STAGES];  // A, upper slices still pending
  logic [WIDTH-1:0] b_q   [STAGES];  // Beff, upper slices still pending

  // Per-stage combinational inputs (stage 0 from ports, else from k-1)
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic             src_c   [STAGES];
  logic             src_v   [STAGES];
  logic             src_sub [STAGES];

  logic [WIDTH-1:0] gs;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    grp_c;
  logic [STAGES-1:0] stage_co;
  logic [STAGES:0]  rdy;
  logic [WIDTH-1:0] s_d [STAGES];

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      src_a[k]   = '0;
      src_b[k]   = '0;
      src_c[k]   = 1'b0;
      src_v[k]   = 1'b0;
      src_sub[k] = 1'b0;
    end
    src_a[0]   = A;
    src_b[0]   = Sub ? ~B : B;
    src_c[0]   = Sub ? ~Cin : Cin;
    src_v[0]   = in_valid;
    src_sub[0] = Sub;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = ctl_q[k-1].carry;
      src_v[k]   = ctl_q[k-1].valid;
      src_sub[k] = ctl_q[k-1].sub;
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int unsigned K = gi / GPS;
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (src_a[K][gi*GROUP +: GROUP]),
      .b   (src_b[K][gi*GROUP +: GROUP]),
      .cin (grp_c[gi]),
      .s   (gs[gi*GROUP +: GROUP]),
      .g   (gg[gi]),
      .p   (gp[gi])
    );
  end

  // One lookahead level across the groups of each stage; index j == GPS
  // yields the carry out of the stage.
  always_comb begin
    logic c;
    logic t;
    int unsigned base;
    grp_c    = '0;
    stage_co = '0;
    c        = 1'b0;
    t        = 1'b0;
    base     = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      base = k * GPS;
      for (int unsigned j = 0; j <= GPS; j++) begin
        c = src_c[k];
        for (int unsigned m = 0; m < j; m++) c = c & gp[base+m];
        for (int unsigned i = 0; i < j; i++) begin
          t = gg[base+i];
          for (int unsigned m = i + 1; m < j; m++) t = t & gp[base+m];
          c = c | t;
        end
        if (j < GPS) grp_c[base+j] = c;
        else         stage_co[k]   = c;
      end
    end
  end

  // Resolved slices ride forward unchanged; stage k adds its own slice.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) s_d[k] = '0;
      else        s_d[k] = s_q[k-1];
      s_d[k][k*SW +: SW] = gs[k*SW +: SW];
    end
  end

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int unsigned k = STAGES; k > 0; k--) begin
      rdy[k-1] = !ctl_q[k-1].valid | rdy[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        s_q[k]   <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          ctl_q[k].valid <= src_v[k];
          ctl_q[k].carry <= stage_co[k];
          ctl_q[k].sub   <= src_sub[k];
          s_q[k]         <= s_d[k];
          a_q[k]         <= src_a[k];
          b_q[k]         <= src_b[k];
        end
      end
    end
  end

`ifdef CLA_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // carry into the MSB recovered from the MSB's sum bit
  assign ovf_d = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ gs[WIDTH-1]
               ^ stage_co[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovf_q <= 1'b0;
    else if (rdy[LAST]) ovf_q <= ovf_d;
  end

  assign Ovf = ovf_q;
`endif

  assign in_ready  = rdy[0];
  assign out_valid = ctl_q[LAST].valid;
  assign S         = s_q[LAST];
  assign Cout      = ctl_q[LAST].carry;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for pipelined_cla_adder.
// The driver pushes model results into a queue on accept; an independent
// monitor pops and compares on every output transfer.
module tb_pipelined_cla_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] S;
  logic         Cout;
`ifdef CLA_OVF_EN
  logic         Ovf;
`endif

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout)
`ifdef CLA_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int unsigned  acc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned cyc = 0;
  int unsigned pushed = 0;
  int unsigned popped = 0;
  int          mode = 1;  // 0: out_ready low, 1: high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic su);
    exp_t   e;
    longint ua, ub, r, sa, sb, rs, mask;
    mask = (longint'(1) << W) - 1;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (su) begin
      r  = ua - ub - longint'(ci);
      rs = sa - sb - longint'(ci);
      e.c = (r >= 0);
    end else begin
      r  = ua + ub + longint'(ci);
      rs = sa + sb + longint'(ci);
      e.c = (r > mask);
    end
    e.s = r[W-1:0];
    e.o = (rs > (mask >> 1)) || (rs < -((mask >> 1) + 1));
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", longint'(out_valid), 0);
        end else begin
          e = q.pop_front();
          popped++;
          check("S", longint'(S), longint'(e.s));
          check("Cout", longint'(Cout), longint'(e.c));
`ifdef CLA_OVF_EN
          check("Ovf", longint'(Ovf), longint'(e.o));
`endif
          if (e.lat) check("latency", longint'(cyc - e.acc), 2);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic su);
    int unsigned n;
    exp_t e;
    n = 0;
    @(negedge clk);
    A = a; B = b; Cin = ci; Sub = su; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", longint'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    e = model(a, b, ci, su);
    e.acc = cyc;
    e.lat = (mode == 1) && out_ready;
    q.push_back(e);
    pushed++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", longint'(q.size()), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far",
             passed, total);
    $fatal(1);
  end

  initial begin : main
    int unsigned base;
    int unsigned n;
    logic [W-1:0] s0;
    logic         c0;

    // Reset with in_valid asserted
    rst_n = 1'b0;
    in_valid = 1'b1;
    A = 16'h1234;
    B = 16'h4321;
    repeat (3) @(negedge clk);
    #3;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_S", longint'(S), 0);
    check("rst_Cout", longint'(Cout), 0);
`ifdef CLA_OVF_EN
    check("rst_Ovf", longint'(Ovf), 0);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", longint'(in_ready), 1);

    // Back-to-back stream, B=3
    mode = 1;
    for (int a = 1; a <= 15; a++) send(W'(a), 16'd3, 1'b0, 1'b0);

    // Cross-stage carry, subtract and overflow corners
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_drain();

    // Backpressure: 4 beats, consumer stalled
    mode = 0;
    base = pushed;
    fork
      begin
        send(16'h1111, 16'h0101, 1'b0, 1'b0);
        send(16'h2222, 16'h0202, 1'b1, 1'b0);
        send(16'h3333, 16'h0303, 1'b0, 1'b1);
        send(16'h4444, 16'h0404, 1'b1, 1'b1);
      end
    join_none
    n = 0;
    while (pushed < base + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    check("bp_out_valid", longint'(out_valid), 1);
    check("bp_in_ready", longint'(in_ready), 0);
    s0 = S;
    c0 = Cout;
    repeat (4) begin
      @(negedge clk);
      #3;
      check("bp_hold_S", longint'(S), longint'(s0));
      check("bp_hold_Cout", longint'(Cout), longint'(c0));
      check("bp_hold_in_ready", longint'(in_ready), 0);
    end
    check("bp_held_beats", longint'(pushed - base), 2);
    mode = 1;
    wait fork;
    wait_drain();
    check("bp_all_out", longint'(popped), longint'(pushed));

    // Asynchronous reset with two beats in flight
    mode = 0;
    send(16'hABCD, 16'h1111, 1'b0, 1'b0);
    send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    check("ar_in_flight", longint'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("ar_out_valid_async", longint'(out_valid), 0);
    check("ar_S_async", longint'(S), 0);
    q.delete();
    popped = pushed;
    mode = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #3;
      check("ar_no_stale", longint'(out_valid), 0);
    end

    // Randomised traffic with random backpressure and input gaps
    mode = 2;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    mode = 1;
    wait_drain();
    check("final_count", longint'(popped), longint'(pushed));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
